// File: rtl/ms_pkg.sv
// Shared definitions for the reveal engine.
// Holds the game-state encoding, the command opcode encoding and the
// default board geometry used by the engine and its bench.
package ms_pkg;

    typedef enum logic [1:0] {
        StPlay  = 2'd0,
        StFlood = 2'd1,
        StLost  = 2'd2,
        StWon   = 2'd3
    } game_state_e;

    typedef enum logic {
        OpReveal = 1'b0,
        OpFlag   = 1'b1
    } cmd_op_e;

    localparam int unsigned DefGridW   = 5;
    localparam int unsigned DefGridH   = 5;
    localparam int unsigned DefAdjBits = 4;

endpackage

// File: rtl/reveal_engine_if.sv
// Command handshake between a player front end (master) and the reveal
// engine (slave).
//   cmd_valid : command offered by the master
//   cmd_ready : engine can accept a command
//   cmd_op    : 0 = reveal, 1 = flag toggle
//   cmd_index : row-major tile index
interface reveal_engine_if #(
    parameter int unsigned IB = 5
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [IB-1:0] cmd_index;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_index,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_index,
        output cmd_ready
    );
endinterface

// File: rtl/pop_count.sv
// Population count of a bit vector, purely combinational.
//   bits_i  : vector to count
//   count_o : number of ones in bits_i
module pop_count #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CW-1:0]    count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/reveal_engine.sv
// Minesweeper reveal engine: accepts reveal / flag-toggle commands, keeps the
// per-tile revealed and flagged vectors and runs a scan-based flood fill
// outward from zero-adjacency tiles.
//   clk, rst       : clock, asynchronous active-high reset
//   new_game_i     : single-cycle pulse that clears the board
//   cmd_if         : command handshake (slave side)
//   mine_map_i     : bit i set = mine at tile i
//   adj_i          : per-tile adjacency counts, ADJ_BITS each
//   revealed_o     : revealed tiles
//   flagged_o      : flagged tiles
//   reveal_count_o : popcount of revealed_o
//   flag_count_o   : popcount of flagged_o
//   game_state_o   : PLAY=0, FLOOD=1, LOST=2, WON=3
module reveal_engine
    import ms_pkg::*;
#(
    parameter int unsigned GRID_W   = DefGridW,
    parameter int unsigned GRID_H   = DefGridH,
    parameter int unsigned ADJ_BITS = DefAdjBits
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      new_game_i,
    reveal_engine_if.slave                            cmd_if,
    input  logic [GRID_W*GRID_H-1:0]                  mine_map_i,
    input  logic [GRID_W*GRID_H*ADJ_BITS-1:0]         adj_i,
    output logic [GRID_W*GRID_H-1:0]                  revealed_o,
    output logic [GRID_W*GRID_H-1:0]                  flagged_o,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0]        reveal_count_o,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0]        flag_count_o,
    output logic [1:0]                                game_state_o
);

    localparam int unsigned N  = GRID_W * GRID_H;
    localparam int unsigned IB = $clog2(N);
    localparam int unsigned CB = $clog2(N + 1);

    logic [N-1:0]  revealed_q, revealed_d;
    logic [N-1:0]  flagged_q, flagged_d;
    game_state_e   state_q, state_d;
    logic [IB-1:0] scan_q, scan_d;
    logic          dirty_q, dirty_d;

    logic [N-1:0]  adj_zero;
    logic [N-1:0]  seed;
    logic [CB-1:0] mine_cnt;
    logic [CB-1:0] safe_cnt;
    logic [IB-1:0] idx;
    logic          idx_ok;
    logic          accept;

    for (genvar i = 0; i < int'(N); i++) begin : g_adj
        assign adj_zero[i] = (adj_i[i*ADJ_BITS +: ADJ_BITS] == '0);
    end

    // Tiles allowed to spread the flood to their neighbours.
    assign seed = revealed_q & ~mine_map_i & adj_zero;

    // True when any in-bounds 8-neighbour of tile t is a seed; row/col bounds
    // keep the test from wrapping across row ends.
    function automatic logic has_seed_nbr(input logic [IB-1:0] t, input logic [N-1:0] s);
        int   r, c, nr, nc;
        logic hit;
        r   = int'(t) / int'(GRID_W);
        c   = int'(t) % int'(GRID_W);
        hit = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = r + dr;
                nc = c + dc;
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < int'(GRID_H) &&
                    nc >= 0 && nc < int'(GRID_W)) begin
                    hit = hit | s[IB'(nr * int'(GRID_W) + nc)];
                end
            end
        end
        return hit;
    endfunction

    pop_count #(.WIDTH(N)) u_pc_rev  (.bits_i(revealed_q), .count_o(reveal_count_o));
    pop_count #(.WIDTH(N)) u_pc_flag (.bits_i(flagged_q),  .count_o(flag_count_o));
    pop_count #(.WIDTH(N)) u_pc_mine (.bits_i(mine_map_i), .count_o(mine_cnt));

    assign safe_cnt         = CB'(N) - mine_cnt;
    assign cmd_if.cmd_ready = (state_q == StPlay);
    assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign idx              = cmd_if.cmd_index;
    assign idx_ok           = (32'(idx) < N);

    always_comb begin
        revealed_d = revealed_q;
        flagged_d  = flagged_q;
        state_d    = state_q;
        scan_d     = scan_q;
        dirty_d    = dirty_q;

        if (new_game_i) begin
            revealed_d = '0;
            flagged_d  = '0;
            scan_d     = '0;
            dirty_d    = 1'b0;
            state_d    = StPlay;
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (accept && idx_ok) begin
                        if (cmd_op_e'(cmd_if.cmd_op) == OpFlag) begin
                            if (!revealed_q[idx]) flagged_d[idx] = ~flagged_q[idx];
                        end else if (!revealed_q[idx] && !flagged_q[idx]) begin
                            revealed_d[idx] = 1'b1;
                            if (mine_map_i[idx])    state_d = StLost;
                            else if (adj_zero[idx]) state_d = StFlood;
                        end
                    end
                    // Loss and flood outrank the win check.
                    if (state_d == StPlay && reveal_count_o == safe_cnt) state_d = StWon;
                end
                StFlood: begin
                    if (!revealed_q[scan_q] && !flagged_q[scan_q] && !mine_map_i[scan_q] &&
                        has_seed_nbr(scan_q, seed)) begin
                        revealed_d[scan_q] = 1'b1;
                        dirty_d            = 1'b1;
                    end
                    if (32'(scan_q) == N - 1) begin
                        scan_d = '0;
                        if (dirty_d) begin
                            dirty_d = 1'b0;
                        end else begin
                            state_d = (reveal_count_o == safe_cnt) ? StWon : StPlay;
                        end
                    end else begin
                        scan_d = scan_q + IB'(1);
                    end
                end
                StLost, StWon: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            revealed_q <= '0;
            flagged_q  <= '0;
            state_q    <= StPlay;
            scan_q     <= '0;
            dirty_q    <= 1'b0;
        end else begin
            revealed_q <= revealed_d;
            flagged_q  <= flagged_d;
            state_q    <= state_d;
            scan_q     <= scan_d;
            dirty_q    <= dirty_d;
        end
    end

    assign revealed_o   = revealed_q;
    assign flagged_o    = flagged_q;
    assign game_state_o = state_q;

endmodule

// File: tb/tb_reveal_engine.sv
// Self-checking bench for reveal_engine on a 5x5 board: directed scenarios
// plus randomized games compared against a pass-level board model.
module tb_reveal_engine;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int AB = 4;
    localparam int N  = W * H;
    localparam int IB = 5;
    localparam int CB = 5;

    localparam int PLAY  = 0;
    localparam int FLOOD = 1;
    localparam int LOST  = 2;
    localparam int WON   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            new_game;
    logic [N-1:0]    mine_map;
    logic [N*AB-1:0] adj;
    logic [N-1:0]    revealed, flagged;
    logic [CB-1:0]   rc, fc;
    logic [1:0]      gs;

    reveal_engine_if #(.IB(IB)) cmd_if ();

    reveal_engine #(.GRID_W(W), .GRID_H(H), .ADJ_BITS(AB)) dut (
        .clk            (clk),
        .rst            (rst),
        .new_game_i     (new_game),
        .cmd_if         (cmd_if),
        .mine_map_i     (mine_map),
        .adj_i          (adj),
        .revealed_o     (revealed),
        .flagged_o      (flagged),
        .reveal_count_o (rc),
        .flag_count_o   (fc),
        .game_state_o   (gs)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model board state.
    logic [N-1:0] m_rev, m_flag;
    int           m_state;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pc(input logic [N-1:0] v);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i]);
        return s;
    endfunction

    function automatic int adj_of(input int i);
        logic [AB-1:0] a;
        a = adj[i*AB +: AB];
        return int'(a);
    endfunction

    function automatic bit is_nbr(input int a, input int b);
        int ra = a / W, ca = a % W, rb = b / W, cb = b % W;
        return (a != b) && (ra - rb <= 1) && (rb - ra <= 1) && (ca - cb <= 1) && (cb - ca <= 1);
    endfunction

    // Real minesweeper adjacency counts from mine_map.
    task automatic build_adj();
        for (int i = 0; i < N; i++) begin
            int cnt = 0;
            for (int j = 0; j < N; j++) if (is_nbr(i, j) && mine_map[j]) cnt++;
            adj[i*AB +: AB] = AB'(cnt);
        end
    endtask

    function automatic int safe_tiles();
        return N - pc(mine_map);
    endfunction

    function automatic bit seed_nbr(input int t);
        for (int b = 0; b < N; b++)
            if (is_nbr(t, b) && m_rev[b] && !mine_map[b] && adj_of(b) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_rev   = '0;
        m_flag  = '0;
        m_state = PLAY;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/revealed"}, 64'(revealed), 64'(m_rev));
        check({tag, "/flagged"},  64'(flagged),  64'(m_flag));
        check({tag, "/rcount"},   64'(rc),       64'(pc(m_rev)));
        check({tag, "/fcount"},   64'(fc),       64'(pc(m_flag)));
        check({tag, "/state"},    64'(gs),       64'(m_state));
        check({tag, "/ready"},    64'(cmd_if.cmd_ready), 64'(m_state == PLAY));
    endtask

    task automatic model_cmd(input logic op, input int idx);
        if (m_state != PLAY || idx >= N) return;
        if (op) begin
            if (!m_rev[idx]) m_flag[idx] = ~m_flag[idx];
        end else if (!m_rev[idx] && !m_flag[idx]) begin
            m_rev[idx] = 1'b1;
            if (mine_map[idx])       m_state = LOST;
            else if (adj_of(idx) == 0) m_state = FLOOD;
        end
    endtask

    // Passes repeat until one reveals nothing; each pass costs N cycles.
    task automatic run_flood(input string tag);
        int passes = 0;
        int cyc    = 0;
        bit dirty;
        do begin
            dirty = 1'b0;
            for (int t = 0; t < N; t++) begin
                if (!m_rev[t] && !m_flag[t] && !mine_map[t] && seed_nbr(t)) begin
                    m_rev[t] = 1'b1;
                    dirty    = 1'b1;
                end
            end
            passes++;
        end while (dirty);
        m_state = (pc(m_rev) == safe_tiles()) ? WON : PLAY;
        while (gs == 2'(FLOOD) && cyc < N * N + 2 * N) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "/flood_cycles"}, 64'(cyc), 64'(passes * N));
        check_all({tag, "/flood_end"});
    endtask

    task automatic sync_won(input string tag);
        if (m_state == PLAY && pc(m_rev) == safe_tiles()) begin
            @(posedge clk);
            #1;
            m_state = WON;
            check_all({tag, "/won"});
        end
    endtask

    task automatic do_cmd(input logic op, input int idx, input string tag);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_index = IB'(idx);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        model_cmd(op, idx);
        check_all(tag);
        if (m_state == FLOOD) run_flood(tag);
        sync_won(tag);
    endtask

    // Command offered while the engine is not ready must change nothing.
    task automatic try_blocked(input string tag);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 1'b0;
        cmd_if.cmd_index = IB'(4);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic pulse_new_game(input logic with_cmd, input string tag);
        new_game         = 1'b1;
        cmd_if.cmd_valid = with_cmd;
        cmd_if.cmd_op    = 1'b0;
        cmd_if.cmd_index = IB'(3);
        @(posedge clk);
        #1;
        new_game         = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        model_clear();
        check_all(tag);
    endtask

    task automatic start_flood_raw();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 1'b0;
        cmd_if.cmd_index = IB'(12);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        check("raw_flood/state", 64'(gs), 64'(FLOOD));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [N-1:0] mask;
        rst              = 1'b1;
        new_game         = 1'b0;
        mine_map         = '0;
        adj              = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 1'b0;
        cmd_if.cmd_index = '0;
        model_clear();
        #12;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Open board: flood from the centre clears everything and wins.
        do_cmd(1'b0, 12, "open_flood");
        check("open_flood/all", 64'(revealed), 64'({N{1'b1}}));
        check("open_flood/rc25", 64'(rc), 64'd25);
        check("open_flood/won", 64'(gs), 64'(WON));
        try_blocked("won_blocked");

        // Mine at tile 0: immediate loss.
        mine_map = '0;
        mine_map[0] = 1'b1;
        build_adj();
        pulse_new_game(1'b0, "ng1");
        do_cmd(1'b0, 0, "hit_mine");
        check("hit_mine/rev0", 64'(revealed[0]), 64'd1);
        try_blocked("lost_blocked");

        // Flag toggles, reveal of a flagged tile, out-of-range indices.
        pulse_new_game(1'b1, "ng_drop");
        do_cmd(1'b1, 7, "flag7_on");
        check("flag7_on/bit", 64'(flagged[7]), 64'd1);
        do_cmd(1'b0, 7, "reveal_flagged");
        check("reveal_flagged/rc", 64'(rc), 64'd0);
        do_cmd(1'b1, 7, "flag7_off");
        check("flag7_off/fc", 64'(fc), 64'd0);
        do_cmd(1'b0, 25, "idx25_reveal");
        do_cmd(1'b1, 31, "idx31_flag");

        // Wall of mines on column 2; flood must stay on columns 0-1.
        mine_map = '0;
        for (int r = 0; r < H; r++) mine_map[r * W + 2] = 1'b1;
        build_adj();
        pulse_new_game(1'b0, "ng_wall");
        do_cmd(1'b0, 0, "wall_flood");
        mask = '0;
        for (int i = 0; i < N; i++) if (i % W < 2) mask[i] = 1'b1;
        check("wall_flood/cols01", 64'(revealed), 64'(mask));
        check("wall_flood/state", 64'(gs), 64'(PLAY));

        // new_game and rst both abort a flood in progress.
        mine_map = '0;
        build_adj();
        pulse_new_game(1'b0, "ng_open");
        start_flood_raw();
        pulse_new_game(1'b1, "ng_mid_flood");
        start_flood_raw();
        rst = 1'b1;
        #1;
        model_clear();
        check_all("rst_mid_flood");
        #1;
        rst = 1'b0;
        do_cmd(1'b1, 24, "after_rst");

        // Randomized games.
        for (int g = 0; g < 20; g++) begin
            for (int i = 0; i < N; i++) mine_map[i] = ($urandom_range(0, 5) == 0);
            if (pc(mine_map) == N) mine_map = '0;
            build_adj();
            pulse_new_game(1'($urandom_range(0, 1)), $sformatf("rg%0d/ng", g));
            for (int k = 0; k < 40 && m_state == PLAY; k++) begin
                do_cmd(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 30)),
                       $sformatf("rg%0d/c%0d", g, k));
            end
            if (m_state != PLAY) try_blocked($sformatf("rg%0d/end", g));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reveal_engine.md
REVEAL_ENGINE -- requirements
Module: reveal_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 5, board columns (2..16).
REQ-002 SHALL have parameter GRID_H, default 5, board rows (2..16); N = GRID_W*GRID_H, IB = $clog2(N), CB = $clog2(N+1).
REQ-003 SHALL have parameter ADJ_BITS, default 4, adjacency count width per tile.
REQ-004 clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 new_game  in  1  single-cycle pulse; clears board state.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  engine can accept a command; high only in PLAY.
REQ-009 cmd_op  in  1  0 = reveal, 1 = flag toggle.
REQ-010 cmd_index  in  IB  row-major tile index, row*GRID_W + col.
REQ-011 mine_map  in  N  bit i = mine at tile i; held stable during a game.
REQ-012 adj  in  N*ADJ_BITS  tile i count at bits [i*ADJ_BITS +: ADJ_BITS].
REQ-013 revealed, flagged  out  N each  per-tile state vectors.
REQ-014 reveal_count, flag_count  out  CB each  popcounts of revealed/flagged.
REQ-015 game_state  out  2  PLAY=0, FLOOD=1, LOST=2, WON=3.

Function
REQ-016 Command transfers on a clk edge where cmd_valid && cmd_ready.
REQ-017 Accepted index >= N: no state change.
REQ-018 Flag toggle: flips flagged[i] next cycle if revealed[i]=0; otherwise no effect.
REQ-019 Reveal on flagged or already-revealed tile: no effect.
REQ-020 Reveal on mine: revealed[i] set next cycle, game_state -> LOST same edge.
REQ-021 Reveal on non-mine with adj!=0: revealed[i] set next cycle, stays PLAY.
REQ-022 Reveal on non-mine with adj==0: revealed[i] set next cycle, game_state -> FLOOD.
REQ-023 FLOOD: scan pointer visits tiles 0..N-1, one per cycle; visited tile t becomes revealed if unrevealed, unflagged, not a mine, and any of its 8 in-bounds neighbours is revealed, non-mine, adj==0.
REQ-024 Neighbour tests SHALL not wrap across row edges or the board boundary.
REQ-025 Per-pass dirty bit set on any reveal; after tile N-1, dirty=1 starts a new pass at 0, dirty=0 exits to PLAY or WON.
REQ-026 Flood SHALL never reveal a mine or a flagged tile; worst case terminates within N passes.
REQ-027 WON entered on the cycle after reveal_count == N - popcount(mine_map) while in PLAY or at FLOOD exit; LOST takes priority.
REQ-028 LOST and WON absorbing except via new_game; cmd_ready=0 there.
REQ-029 new_game pulse (any state, including mid-FLOOD) clears revealed, flagged, scan pointer, dirty; next state PLAY; has priority over a same-cycle command, which is dropped.
REQ-030 reveal_count and flag_count combinational from vectors, zero latency.

Reset
REQ-031 rst high asynchronously forces revealed=0, flagged=0, counts=0, game_state=PLAY, cmd_ready=1, scan pointer=0, dirty=0.
REQ-032 Release of rst needs no command; first command accepted on first edge after release.

Structure
REQ-033 Package ms_pkg SHALL hold game-state enum, cmd_op encoding, default GRID_W/GRID_H/ADJ_BITS.
REQ-034 Counts SHALL use one sub-module pop_count (parametrised width), instanced twice plus once for mine_map.
REQ-035 Neighbour predicate is a function of index, not a per-tile unrolled instance.

Verification
REQ-036 5x5, no mines, adj=0: reveal idx 12 -> FLOOD, all 25 revealed after 2 passes, state WON, reveal_count=25.
REQ-037 Mine at 0, adj[1]=1: reveal 0 -> revealed[0]=1, LOST next edge, cmd_ready=0.
REQ-038 Flag 7 twice -> flagged[7] 1 then 0, flag_count 1 then 0; reveal 7 while flagged -> no change.
REQ-039 Mines on column 2 (idx 2,7,12,17,22), adj=0 elsewhere except column 1/3 nonzero: reveal 0 -> only columns 0-1 revealed; no reveal crosses column 4 to column 0 of the next row.
REQ-040 new_game during FLOOD pass 1 -> next cycle vectors 0, PLAY, cmd_ready=1; assert rst mid-FLOOD -> same values immediately.
REQ-041 Index 25 reveal on 5x5 -> accepted, no state change.
